// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the two-port memory bus arbiter.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WDATA,
        RDATA,
        DONE
    } arb_state_t;

    typedef enum logic {
        OWN_IC,
        OWN_DC
    } arb_owner_t;

    localparam int DEF_BEATS        = 8;
    localparam int DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Two-requester burst arbiter for the external memory bus.
// The IF side (I-cache fill) and the MEM side (D-cache fill/writeback) share one
// bus; one fixed-length burst runs at a time and read beats go only to the owner.
// Optional build macro MEM_ARB_STARVE_EN: lets the IF side win a tie after
// STARVE_LIMIT consecutive MEM-side wins. Without it the MEM side has strict
// priority.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int BEATS        = DEF_BEATS,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_gnt,
    output logic              ic_rvalid,
    output logic              ic_done,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_wnext,
    output logic              dc_gnt,
    output logic              dc_rvalid,
    output logic              dc_done,
    output logic [DATA_W-1:0] rdata,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic              bus_req_we,
    output logic [ADDR_W-1:0] bus_req_addr,
    output logic              bus_wvalid,
    input  logic              bus_wready,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam int              CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if (BEATS < 2 || STARVE_LIMIT < 1) begin : g_bad_param
        $error("mem_bus_arbiter: BEATS must be >= 2 and STARVE_LIMIT >= 1");
    end

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic if_wins;
    logic any_req;
    assign any_req = ic_req | dc_req;

`ifdef MEM_ARB_STARVE_EN
    localparam int              SC_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] SC_LIMIT  = SC_W'(STARVE_LIMIT);

    logic [SC_W-1:0] starve_q, starve_d;

    assign if_wins = ic_req & (~dc_req | (starve_q == SC_LIMIT));

    // Count MEM-side wins taken while the IF side was also waiting.
    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE && any_req) begin
            if (!ic_req || if_wins) starve_d = '0;
            else                    starve_d = starve_q + 1'b1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) starve_q <= '0;
        else          starve_q <= starve_d;
    end
`else
    assign if_wins = ic_req & ~dc_req;
`endif

    // State, ownership, latched request and beat counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= OWN_IC;
            addr_q  <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: arbitration in IDLE, then request, beats, and a done cycle.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = REQ;
                    if (if_wins) begin
                        owner_d = OWN_IC;
                        addr_d  = ic_addr;
                        we_d    = 1'b0;
                    end else begin
                        owner_d = OWN_DC;
                        addr_d  = dc_addr;
                        we_d    = dc_we;
                    end
                end
            end
            REQ: begin
                if (bus_req_ready) begin
                    cnt_d   = '0;
                    state_d = we_q ? WDATA : RDATA;
                end
            end
            WDATA: begin
                if (bus_wready) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RDATA: begin
                if (bus_rvalid) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic own_ic, busy, rd_beat, in_req, in_wdata;
    assign own_ic   = (owner_q == OWN_IC);
    assign busy     = (state_q != IDLE);
    assign in_req   = (state_q == REQ);
    assign in_wdata = (state_q == WDATA);
    assign rd_beat  = (state_q == RDATA) & bus_rvalid;

    // Outputs are gated by state so everything reads 0 while idle or in reset.
    assign ic_gnt        = busy & own_ic;
    assign dc_gnt        = busy & ~own_ic;
    assign bus_req_valid = in_req;
    assign bus_req_we    = in_req & we_q;
    assign bus_req_addr  = in_req ? addr_q : '0;
    assign bus_wvalid    = in_wdata;
    assign bus_wdata     = in_wdata ? dc_wdata : '0;
    assign dc_wnext      = in_wdata & bus_wready;
    assign rdata         = rd_beat ? bus_rdata : '0;
    assign ic_rvalid     = rd_beat & own_ic;
    assign dc_rvalid     = rd_beat & ~own_ic;
    assign ic_done       = (state_q == DONE) & own_ic;
    assign dc_done       = (state_q == DONE) & ~own_ic;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single external memory bus between two requesters: the instruction-cache fill port (IF side) and the data-cache fill/writeback port (MEM side).
- Grants one requester at a time and sequences a fixed-length burst transaction (request, write beats, read beats, done).
- Returns the response beats only to the granted requester.
- Sits between the two caches and the bus interface. Cache misses seen as if_stall / mem_stall by pipeline control resolve when this block pulses done.

Parameters:
- ADDR_W, 64, bus/request address width.
- DATA_W, 64, width of one data beat.
- BEATS, 8, beats per burst (line size / DATA_W); must be >= 2.
- STARVE_LIMIT, 4, consecutive MEM-side wins allowed while IF side waits (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- ic_req  in  1  IF-side line read request; held until ic_done
- ic_addr  in  ADDR_W  line-aligned read address; stable while ic_req
- ic_gnt  out  1  IF side owns the bus
- ic_rvalid  out  1  read beat valid for IF side
- ic_done  out  1  one-cycle pulse: IF transaction complete
- dc_req  in  1  MEM-side request; held until dc_done
- dc_we  in  1  1 = writeback burst, 0 = fill read; stable while dc_req
- dc_addr  in  ADDR_W  line-aligned address
- dc_wdata  in  DATA_W  current write beat
- dc_wnext  out  1  pulse: current write beat accepted; advance dc_wdata
- dc_gnt  out  1  MEM side owns the bus
- dc_rvalid  out  1  read beat valid for MEM side
- dc_done  out  1  one-cycle pulse: MEM transaction complete
- rdata  out  DATA_W  read beat data, shared by both requesters (qualified by ic_rvalid / dc_rvalid)
- bus_req_valid  out  1  request phase valid
- bus_req_ready  in  1  bus accepts request
- bus_req_we  out  1  request is a write
- bus_req_addr  out  ADDR_W  request address
- bus_wvalid  out  1  write beat valid
- bus_wready  in  1  bus accepts write beat
- bus_wdata  out  DATA_W  write beat
- bus_rvalid  in  1  read beat valid; no backpressure
- bus_rdata  in  DATA_W  read beat

Behaviour:
- Reset: asynchronous. Forces state IDLE and clears beat counter and starvation counter. All outputs read 0 during and after reset.
- Reset mid-transaction abandons the transaction; the bus side is reset by the same reset_n.
- States: IDLE, REQ, WDATA, RDATA, DONE.
  - IDLE: arbitrate among asserted requests.
    - Default: MEM side wins on a tie.
    - If a winner exists, latch owner, addr and we, then go to REQ next cycle.
    - ic_gnt / dc_gnt assert from that cycle and stay high through DONE inclusive.
  - REQ: bus_req_valid=1 with latched addr/we. On bus_req_valid && bus_req_ready, go to WDATA if we, else to RDATA; beat counter=0.
  - WDATA (MEM side only):
    - bus_wvalid=1, bus_wdata=dc_wdata combinationally.
    - Each cycle with bus_wready: dc_wnext=1, counter++.
    - On beat BEATS-1 accepted, go to DONE.
  - RDATA:
    - Each bus_rvalid: rdata=bus_rdata (combinational pass-through), owner's rvalid=1, counter++.
    - On beat BEATS-1, go to DONE.
    - bus_rvalid outside RDATA is ignored.
  - DONE: owner's done=1 for exactly one cycle, then IDLE.
- Gap rule: the earliest new grant is registered in the IDLE cycle after DONE, so gnt drops for at least one cycle between bursts.
- Counter width: $clog2(BEATS); wraps to 0 on DONE entry.
- Requester deasserting req mid-transaction is a protocol violation. The arbiter completes the burst regardless and never cancels.
- Request inputs are sampled only in IDLE; changes at other times are ignored.
- Latency, read with ready=1 and back-to-back rvalid: req at cycle 0 -> gnt/req_valid at cycle 1 -> beats from cycle 2 -> done at cycle 2+BEATS.

Optional Feature:
- Macro: MEM_ARB_STARVE_EN.
- Defined:
  - A counter increments on each IDLE arbitration won by the MEM side while ic_req=1.
  - It resets to 0 on any IF-side grant, or on an arbitration where ic_req=0.
  - When the counter equals STARVE_LIMIT, IF side wins the next tie.
- Undefined: strict MEM-side priority; no counter logic. IF side can starve indefinitely.

Decomposition:
- Package mem_arb_pkg holds:
  - enum arb_state_t {IDLE, REQ, WDATA, RDATA, DONE}
  - enum arb_owner_t {OWN_IC, OWN_DC}
  - default constants for BEATS and STARVE_LIMIT
- No sub-module is required. The starvation counter may be a small sub-module, mem_arb_starve_ctr, compiled only under MEM_ARB_STARVE_EN.

Test Plan:
- IF read alone: ic_req=1, ic_addr=0x1000, bus_req_ready high at cycle 3, rvalid beats 0..7 with data=beat index -> bus_req_addr=0x1000, ic_rvalid x8 with rdata 0..7, ic_done one cycle after beat 7, dc_* outputs stay 0.
- Tie: ic_req and dc_req (dc_we=0) rise the same cycle -> dc_gnt first, dc_done; ic_gnt asserts 2 cycles after dc_done's cycle with a 1-cycle gap.
- MEM write: dc_we=1, bus_wready toggling 1,0,1,0... -> exactly 8 dc_wnext pulses, bus_wdata matches dc_wdata on each accepted beat, no ic activity.
- Starvation (STARVE_LIMIT=4, both reqs held, dc requesting back-to-back):
  - With MEM_ARB_STARVE_EN: the 5th arbitration grants IF.
  - Without the macro: IF is never granted while dc_req stays high.
- Reset mid-burst: reset_n low after read beat 3 -> all outputs 0 immediately (asynchronous). After release: IDLE, a new ic_req receives a full 8 beats and counter starts at 0.
